// File: rtl/eth_link_ctrl_10g.sv
// eth_link_ctrl_10g: 10G link bring-up and supervision controller (logic_clk domain).
// Sequences the PHY reset, the MAC enables and the IFG from synchronized PHY status.
// Retries on lock timeout and tears the link down on lock loss or a bad-block burst.
// Keeps saturating link-down and bad-block counters for software.
// Ports: clk, rst (sync, active high); ctrl_enable/ctrl_restart/cfg_ifg_in (control);
//   rx_block_lock/rx_high_ber/rx_status/rx_bad_block (PHY status);
//   phy_reset, cfg_tx_enable, cfg_rx_enable, cfg_ifg (sequenced controls);
//   link_up, ctrl_state, retry_fail, link_down_count, bad_block_count (status).
module eth_link_ctrl_10g #(
    parameter int unsigned RESET_CYCLES     = 64,
    parameter int unsigned LOCK_TIMEOUT     = 1000000,
    parameter int unsigned STABLE_CYCLES    = 1024,
    parameter int unsigned HOLDOFF_CYCLES   = 256,
    parameter int unsigned MAX_RETRIES      = 8,
    parameter int unsigned BAD_BLOCK_LIMIT  = 16,
    parameter int unsigned BAD_BLOCK_WINDOW = 65536,
    parameter int unsigned TIMER_WIDTH      = 24,
    parameter int unsigned CNT_WIDTH        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_enable,
    input  logic                 ctrl_restart,
    input  logic [7:0]           cfg_ifg_in,
    input  logic                 rx_block_lock,
    input  logic                 rx_high_ber,
    input  logic                 rx_status,
    input  logic                 rx_bad_block,
    output logic                 phy_reset,
    output logic                 cfg_tx_enable,
    output logic                 cfg_rx_enable,
    output logic [7:0]           cfg_ifg,
    output logic                 link_up,
    output logic [2:0]           ctrl_state,
    output logic                 retry_fail,
    output logic [CNT_WIDTH-1:0] link_down_count,
    output logic [CNT_WIDTH-1:0] bad_block_count
);

    typedef enum logic [2:0] {
        S_DISABLED  = 3'd0,
        S_PHY_RST   = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STABILIZE = 3'd3,
        S_UP        = 3'd4,
        S_HOLDOFF   = 3'd5,
        S_FAILED    = 3'd6
    } state_e;

    localparam int unsigned WIN_W   = (BAD_BLOCK_WINDOW > 1) ? $clog2(BAD_BLOCK_WINDOW) : 1;
    localparam int unsigned BB_W    = $clog2(BAD_BLOCK_LIMIT + 1);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    // Timer compares use N-1: the timer is 0 in the first cycle of a state,
    // so each timed state lasts exactly N cycles.
    localparam logic [TIMER_WIDTH-1:0] T_RST  = TIMER_WIDTH'(RESET_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] T_LOCK = TIMER_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] T_STAB = TIMER_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] T_HOLD = TIMER_WIDTH'(HOLDOFF_CYCLES - 1);
    localparam logic [WIN_W-1:0]       WIN_LAST  = WIN_W'(BAD_BLOCK_WINDOW - 1);
    localparam logic [BB_W-1:0]        BB_LIM    = BB_W'(BAD_BLOCK_LIMIT);
    localparam logic [RETRY_W-1:0]     RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [7:0]             IFG_MIN   = 8'd12;

    state_e                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic [WIN_W-1:0]       win_q, win_d;
    logic [BB_W-1:0]        bbw_q, bbw_d;
    logic                   ber_loss_q, ber_loss_d;
    logic                   phy_reset_q, phy_reset_d;
    logic                   enable_q, enable_d;
    logic                   retry_fail_q, retry_fail_d;
    logic [7:0]             cfg_ifg_q, cfg_ifg_d;
    logic [CNT_WIDTH-1:0]   ldc_q, ldc_d;
    logic [CNT_WIDTH-1:0]   bbc_q, bbc_d;

    logic            good;
    logic            enter;
    logic            ldc_inc;
    logic            bbc_inc;
    logic [BB_W-1:0] bb_next;

    assign good = rx_block_lock & ~rx_high_ber & rx_status;

    always_comb begin
        state_d    = state_q;
        enter      = 1'b0;
        retry_d    = retry_q;
        ber_loss_d = ber_loss_q;
        win_d      = win_q;
        bbw_d      = bbw_q;
        ldc_inc    = 1'b0;
        bbc_inc    = (state_q == S_UP) & rx_bad_block;
        // A pulse in the wrap cycle opens the new window with a count of 1.
        bb_next    = (win_q == WIN_LAST) ? BB_W'(rx_bad_block)
                                         : bbw_q + BB_W'(rx_bad_block);

        if (!ctrl_enable) begin
            if (state_q != S_DISABLED) begin
                state_d = S_DISABLED;
                enter   = 1'b1;
            end
        end else if (ctrl_restart && state_q != S_DISABLED) begin
            state_d = S_PHY_RST;
            enter   = 1'b1;
            retry_d = '0;
            ldc_inc = (state_q == S_UP);
        end else begin
            unique case (state_q)
                S_DISABLED: begin
                    state_d = S_PHY_RST;
                    enter   = 1'b1;
                end
                S_PHY_RST: begin
                    if (timer_q == T_RST) begin
                        state_d = S_WAIT_LOCK;
                        enter   = 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (good) begin
                        state_d = S_STABILIZE;
                        enter   = 1'b1;
                    end else if (timer_q == T_LOCK) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = (retry_d == RETRY_MAX) ? S_FAILED : S_PHY_RST;
                        enter   = 1'b1;
                    end
                end
                S_STABILIZE: begin
                    if (!good) begin
                        state_d = S_WAIT_LOCK;
                        enter   = 1'b1;
                    end else if (timer_q == T_STAB) begin
                        state_d = S_UP;
                        enter   = 1'b1;
                        retry_d = '0;
                    end
                end
                S_UP: begin
                    win_d = (win_q == WIN_LAST) ? '0 : win_q + WIN_W'(1);
                    bbw_d = bb_next;
                    // A bad-block burst needs a full PHY reset, so it wins over lock loss.
                    if (bb_next == BB_LIM) begin
                        state_d    = S_HOLDOFF;
                        enter      = 1'b1;
                        ber_loss_d = 1'b1;
                        ldc_inc    = 1'b1;
                    end else if (!good) begin
                        state_d    = S_HOLDOFF;
                        enter      = 1'b1;
                        ber_loss_d = 1'b0;
                        ldc_inc    = 1'b1;
                    end
                end
                S_HOLDOFF: begin
                    if (timer_q == T_HOLD) begin
                        state_d = ber_loss_q ? S_PHY_RST : S_WAIT_LOCK;
                        enter   = 1'b1;
                    end
                end
                S_FAILED: begin
                end
                default: begin
                    state_d = S_DISABLED;
                    enter   = 1'b1;
                end
            endcase
        end

        // Re-enabling from DISABLED starts a fresh set of lock attempts.
        if (state_d == S_DISABLED) retry_d = '0;
        if (enter && state_d == S_UP) begin
            win_d = '0;
            bbw_d = '0;
        end

        timer_d = enter ? '0 : ((timer_q == '1) ? timer_q : timer_q + TIMER_WIDTH'(1));

        phy_reset_d  = (state_d == S_DISABLED) || (state_d == S_PHY_RST);
        enable_d     = (state_d == S_UP);
        retry_fail_d = (state_d == S_FAILED);
        cfg_ifg_d    = (state_q == S_UP) ? cfg_ifg_q
                     : ((cfg_ifg_in < IFG_MIN) ? IFG_MIN : cfg_ifg_in);
        ldc_d = (ldc_inc && ldc_q != '1) ? ldc_q + CNT_WIDTH'(1) : ldc_q;
        bbc_d = (bbc_inc && bbc_q != '1) ? bbc_q + CNT_WIDTH'(1) : bbc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_DISABLED;
            timer_q      <= '0;
            retry_q      <= '0;
            win_q        <= '0;
            bbw_q        <= '0;
            ber_loss_q   <= 1'b0;
            phy_reset_q  <= 1'b1;
            enable_q     <= 1'b0;
            retry_fail_q <= 1'b0;
            cfg_ifg_q    <= IFG_MIN;
            ldc_q        <= '0;
            bbc_q        <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            win_q        <= win_d;
            bbw_q        <= bbw_d;
            ber_loss_q   <= ber_loss_d;
            phy_reset_q  <= phy_reset_d;
            enable_q     <= enable_d;
            retry_fail_q <= retry_fail_d;
            cfg_ifg_q    <= cfg_ifg_d;
            ldc_q        <= ldc_d;
            bbc_q        <= bbc_d;
        end
    end

    assign phy_reset       = phy_reset_q;
    assign cfg_tx_enable   = enable_q;
    assign cfg_rx_enable   = enable_q;
    assign link_up         = enable_q;
    assign cfg_ifg         = cfg_ifg_q;
    assign ctrl_state      = state_q;
    assign retry_fail      = retry_fail_q;
    assign link_down_count = ldc_q;
    assign bad_block_count = bbc_q;

endmodule

// File: tb/tb_eth_link_ctrl_10g.sv
// tb_eth_link_ctrl_10g: directed self-checking bench for eth_link_ctrl_10g.
// Shortened lock timeout, holdoff and bad-block window keep the run small.
module tb_eth_link_ctrl_10g;

    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          ctrl_enable;
    logic          ctrl_restart;
    logic [7:0]    cfg_ifg_in;
    logic          rx_block_lock;
    logic          rx_high_ber;
    logic          rx_status;
    logic          rx_bad_block;
    logic          phy_reset;
    logic          cfg_tx_enable;
    logic          cfg_rx_enable;
    logic [7:0]    cfg_ifg;
    logic          link_up;
    logic [2:0]    ctrl_state;
    logic          retry_fail;
    logic [CW-1:0] link_down_count;
    logic [CW-1:0] bad_block_count;

    int vectors;
    int miscompares;

    eth_link_ctrl_10g #(
        .RESET_CYCLES    (64),
        .LOCK_TIMEOUT    (100),
        .STABLE_CYCLES   (1024),
        .HOLDOFF_CYCLES  (32),
        .MAX_RETRIES     (3),
        .BAD_BLOCK_LIMIT (16),
        .BAD_BLOCK_WINDOW(256),
        .TIMER_WIDTH     (24),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ctrl_enable    (ctrl_enable),
        .ctrl_restart   (ctrl_restart),
        .cfg_ifg_in     (cfg_ifg_in),
        .rx_block_lock  (rx_block_lock),
        .rx_high_ber    (rx_high_ber),
        .rx_status      (rx_status),
        .rx_bad_block   (rx_bad_block),
        .phy_reset      (phy_reset),
        .cfg_tx_enable  (cfg_tx_enable),
        .cfg_rx_enable  (cfg_rx_enable),
        .cfg_ifg        (cfg_ifg),
        .link_up        (link_up),
        .ctrl_state     (ctrl_state),
        .retry_fail     (retry_fail),
        .link_down_count(link_down_count),
        .bad_block_count(bad_block_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ticks until ctrl_state equals s, giving up after limit ticks.
    task automatic wait_state(input logic [2:0] s, input int limit, output int n);
        n = 0;
        while (ctrl_state !== s && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int pulses;
        logic prev;
        logic saw;

        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        ctrl_enable   = 1'b1;
        ctrl_restart  = 1'b0;
        cfg_ifg_in    = 8'd5;
        rx_block_lock = 1'b1;
        rx_high_ber   = 1'b0;
        rx_status     = 1'b1;
        rx_bad_block  = 1'b0;
        repeat (3) tick();

        chk("rst_state", 32'(ctrl_state), 0);
        chk("rst_phy_reset", 32'(phy_reset), 1);
        chk("rst_tx_en", 32'(cfg_tx_enable), 0);
        chk("rst_link_up", 32'(link_up), 0);
        chk("rst_ifg", 32'(cfg_ifg), 12);
        chk("rst_ldc", 32'(link_down_count), 0);

        // Bring-up with good status throughout.
        rst = 1'b0;
        tick();
        chk("t1_phy_rst_state", 32'(ctrl_state), 1);
        n = 0;
        while (phy_reset === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("t1_phy_reset_len", 32'(n), 64);
        chk("t1_wait_lock", 32'(ctrl_state), 2);
        n = 0;
        while (link_up !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk("t1_up_latency", 32'(n), 1025);
        chk("t1_up_state", 32'(ctrl_state), 4);
        chk("t1_rx_en", 32'(cfg_rx_enable), 1);
        chk("t1_ifg_clamp", 32'(cfg_ifg), 12);
        cfg_ifg_in = 8'd20;
        repeat (5) tick();
        chk("t1_ifg_frozen", 32'(cfg_ifg), 12);

        // One-cycle lock drop: HOLDOFF then WAIT_LOCK without PHY reset.
        rx_block_lock = 1'b0;
        tick();
        rx_block_lock = 1'b1;
        chk("t3_holdoff", 32'(ctrl_state), 5);
        chk("t3_tx_off", 32'(cfg_tx_enable), 0);
        chk("t3_ldc", 32'(link_down_count), 1);
        n   = 0;
        saw = 1'b0;
        while (ctrl_state === 3'd5 && n < 100) begin
            saw = saw | phy_reset;
            tick();
            n++;
        end
        chk("t3_holdoff_len", 32'(n), 32);
        chk("t3_to_wait_lock", 32'(ctrl_state), 2);
        chk("t3_no_phy_reset", 32'(saw | phy_reset), 0);
        wait_state(3'd4, 2000, n);
        chk("t3_up_latency", 32'(n), 1025);
        chk("t3_ifg_reload", 32'(cfg_ifg), 20);

        // 16 back-to-back bad blocks trip the link with a BER loss.
        rx_bad_block = 1'b1;
        repeat (15) tick();
        chk("t4_15_still_up", 32'(link_up), 1);
        tick();
        rx_bad_block = 1'b0;
        chk("t4_16_holdoff", 32'(ctrl_state), 5);
        chk("t4_bbc", 32'(bad_block_count), 16);
        chk("t4_ldc", 32'(link_down_count), 2);
        wait_state(3'd1, 100, n);
        chk("t4_holdoff_to_rst", 32'(n), 32);
        chk("t4_phy_reset", 32'(phy_reset), 1);

        // Burst split across a window wrap: 10 old + 15 new stays up, 16th new trips.
        wait_state(3'd4, 2000, n);
        chk("t4_up_again", 32'(n), 64 + 1025);
        repeat (245) tick();
        rx_bad_block = 1'b1;
        repeat (25) tick();
        chk("t4_wrap_still_up", 32'(link_up), 1);
        tick();
        rx_bad_block = 1'b0;
        chk("t4_wrap_trip", 32'(ctrl_state), 5);
        chk("t4_wrap_bbc", 32'(bad_block_count), 42);
        chk("t4_wrap_ldc", 32'(link_down_count), 3);

        // Lock never comes: three reset attempts, then FAILED.
        rx_block_lock = 1'b0;
        ctrl_restart  = 1'b1;
        tick();
        ctrl_restart  = 1'b0;
        chk("t2_restart_rst", 32'(ctrl_state), 1);
        pulses = 1;
        prev   = phy_reset;
        n      = 0;
        while (retry_fail !== 1'b1 && n < 1000) begin
            tick();
            n++;
            if (phy_reset === 1'b1 && prev === 1'b0) pulses++;
            prev = phy_reset;
        end
        chk("t2_fail_time", 32'(n), 492);
        chk("t2_pulses", 32'(pulses), 3);
        chk("t2_failed_state", 32'(ctrl_state), 6);
        chk("t2_failed_phy", 32'(phy_reset), 0);
        repeat (10) tick();
        chk("t2_failed_hold", 32'(retry_fail), 1);
        ctrl_restart = 1'b1;
        tick();
        ctrl_restart = 1'b0;
        chk("t2_restart_clr", 32'(retry_fail), 0);
        chk("t2_restart_phy", 32'(phy_reset), 1);
        chk("t2_ldc_kept", 32'(link_down_count), 3);

        // Disable and restart together in UP: disable wins, no link-down count.
        rx_block_lock = 1'b1;
        wait_state(3'd4, 2000, n);
        chk("t5_up", 32'(link_up), 1);
        ctrl_enable  = 1'b0;
        ctrl_restart = 1'b1;
        tick();
        ctrl_restart = 1'b0;
        chk("t5_disabled", 32'(ctrl_state), 0);
        chk("t5_dis_phy", 32'(phy_reset), 1);
        chk("t5_dis_ldc", 32'(link_down_count), 3);

        // Restart from UP counts a link-down.
        ctrl_enable = 1'b1;
        wait_state(3'd4, 2000, n);
        chk("t5_up2", 32'(n), 1 + 64 + 1025);
        ctrl_restart = 1'b1;
        tick();
        ctrl_restart = 1'b0;
        chk("t5_restart_up", 32'(ctrl_state), 1);
        chk("t5_restart_ldc", 32'(link_down_count), 4);

        // Glitch in STABILIZE restarts the stability count.
        wait_state(3'd3, 200, n);
        chk("t5_stab", 32'(ctrl_state), 3);
        repeat (999) tick();
        chk("t5_stab_999", 32'(ctrl_state), 3);
        rx_high_ber = 1'b1;
        tick();
        rx_high_ber = 1'b0;
        chk("t5_glitch", 32'(ctrl_state), 2);
        n = 0;
        while (link_up !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk("t5_regain", 32'(n), 1025);

        // Reset mid-operation clears counters.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_state", 32'(ctrl_state), 0);
        chk("rst2_ldc", 32'(link_down_count), 0);
        chk("rst2_bbc", 32'(bad_block_count), 0);
        chk("rst2_link", 32'(link_up), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
